// File: rtl/sw_debounce_if.sv
// Switch-conditioning bundle: raw switch levels in; debounced levels, edge pulses and the soc reset out.
interface sw_debounce_if #(parameter int N_SW = 8);
    logic [N_SW-1:0] sw_raw;
    logic [N_SW-1:0] sw_stable;
    logic [N_SW-1:0] sw_rise;
    logic [N_SW-1:0] sw_fall;
    logic            soc_rst_n;

    modport master (output sw_raw, input sw_stable, sw_rise, sw_fall, soc_rst_n);
    modport slave  (input sw_raw, output sw_stable, sw_rise, sw_fall, soc_rst_n);
endinterface

// File: rtl/sw_debounce.sv
// Synchronises and debounces the slide-switch bank and stretches the soc reset.
// Define SW_EDGE_DETECT_EN to generate the sw_rise/sw_fall pulses; otherwise they are tied to 0.
module sw_debounce #(
    parameter int N_SW         = 8,
    parameter int DEBOUNCE_CYC = 50000,
    parameter int RST_HOLD     = 16,
    parameter int RST_IDX      = 7
) (
    input  logic         clk,
    input  logic         rst,
    sw_debounce_if.slave sw
);
    localparam int CW = $clog2(DEBOUNCE_CYC + 1);
    localparam int HW = (RST_HOLD > 0) ? $clog2(RST_HOLD + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(DEBOUNCE_CYC - 1);
    localparam logic [HW-1:0] HOLD_INIT = HW'(RST_HOLD);

    logic [N_SW-1:0]         sync1_q, sync2_q;
    logic [N_SW-1:0][CW-1:0] cnt_q, cnt_d;
    logic [N_SW-1:0]         stable_q, stable_d;
    logic [HW-1:0]           hold_q, hold_d;
    logic                    socRstN_q, socRstN_d;

    // A bit accepts a new level only after an unbroken run of mismatching synchronised samples.
    always_comb begin
        cnt_d    = cnt_q;
        stable_d = stable_q;
        for (int i = 0; i < N_SW; i++) begin
            if (sync2_q[i] == stable_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
                cnt_d[i]    = '0;
                stable_d[i] = sync2_q[i];
            end else begin
                cnt_d[i] = cnt_q[i] + CW'(1);
            end
        end
        hold_d    = (hold_q == '0) ? '0 : hold_q - HW'(1);
        socRstN_d = (hold_q == '0) && stable_q[RST_IDX];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            cnt_q     <= '0;
            stable_q  <= '0;
            hold_q    <= HOLD_INIT;
            socRstN_q <= 1'b0;
        end else begin
            sync1_q   <= sw.sw_raw;
            sync2_q   <= sync1_q;
            cnt_q     <= cnt_d;
            stable_q  <= stable_d;
            hold_q    <= hold_d;
            socRstN_q <= socRstN_d;
        end
    end

`ifdef SW_EDGE_DETECT_EN
    logic [N_SW-1:0] rise_q, fall_q;

    // Pulses land on the same edge as the stable level they describe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rise_q <= '0;
            fall_q <= '0;
        end else begin
            rise_q <= (stable_d ^ stable_q) & stable_d;
            fall_q <= (stable_d ^ stable_q) & ~stable_d;
        end
    end

    assign sw.sw_rise = rise_q;
    assign sw.sw_fall = fall_q;
`else
    assign sw.sw_rise = '0;
    assign sw.sw_fall = '0;
`endif

    assign sw.sw_stable = stable_q;
    assign sw.soc_rst_n = socRstN_q;
endmodule
